// File: rtl/alu_cmd_issue.sv
// Issue stage for the 8-bit ALU: command FIFO -> ALU -> result register, 2 edges minimum cmd to result.
// Backpressure: cmd_ready drops when the FIFO is full; the head issues only when the result register is free or popping.

module alu_cmd_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_dat,
  output logic          o_push_rdy,
  output logic [CW-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_empty;

  assign w_empty    = (r_count == '0);
  assign o_push_rdy = (r_count != CW'(DEPTH));
  assign o_count    = r_count;
  // Head reads as zero when empty so the ALU never sees stale operands.
  assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_A,
  input  logic [7:0]    cmd_B,
  input  logic [3:0]    cmd_Sel,
  output logic [7:0]    A,
  output logic [7:0]    B,
  output logic [3:0]    ALU_Sel,
  input  logic [15:0]   ALU_Out,
  input  logic          CarryOut,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_Data,
  output logic [3:0]    res_Sel,
  output logic          res_Carry,
  output logic          res_Zero,
  output logic          res_DivErr,
  output logic [CW-1:0] count
);
  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_DIV = 4'b0011;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  cmd_t          w_push_dat;
  cmd_t          w_head;
  logic          w_push;
  logic          w_issue;
  logic          w_div0;
  logic [CW-1:0] w_count;

  logic          r_res_valid;
  logic [15:0]   r_res_data;
  logic [3:0]    r_res_sel;
  logic          r_res_carry;
  logic          r_res_zero;
  logic          r_res_diverr;

  assign w_push_dat = '{a: cmd_A, b: cmd_B, sel: cmd_Sel};
  assign w_push     = cmd_valid && cmd_ready;
  assign w_issue    = (w_count != '0) && (!r_res_valid || res_ready);

  alu_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_issue),
    .o_head_dat (w_head),
    .o_push_rdy (cmd_ready),
    .o_count    (w_count)
  );

  assign A       = w_head.a;
  assign B       = w_head.b;
  assign ALU_Sel = w_head.sel;
  assign count   = w_count;

  assign w_div0 = (w_head.sel == SEL_DIV) && (w_head.b == 8'd0);

  // An issue in the same cycle as a pop reloads the register, keeping res_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_sel    <= '0;
      r_res_carry  <= 1'b0;
      r_res_zero   <= 1'b0;
      r_res_diverr <= 1'b0;
    end else if (w_issue) begin
      r_res_valid  <= 1'b1;
      r_res_sel    <= w_head.sel;
      r_res_carry  <= (w_head.sel == SEL_ADD) ? CarryOut : 1'b0;
      r_res_data   <= w_div0 ? 16'hFFFF : ALU_Out;
      r_res_zero   <= w_div0 ? 1'b0 : (ALU_Out == 16'd0);
      r_res_diverr <= w_div0;
    end else if (res_ready) begin
      r_res_valid  <= 1'b0;
    end
  end

  assign res_valid  = r_res_valid;
  assign res_Data   = r_res_data;
  assign res_Sel    = r_res_sel;
  assign res_Carry  = r_res_carry;
  assign res_Zero   = r_res_zero;
  assign res_DivErr = r_res_diverr;
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Scoreboard bench for alu_cmd_issue with a behavioural ALU on the A/B/ALU_Sel side.
module tb_alu_cmd_issue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        diverr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, res_ready, res_valid;
  logic [7:0]    cmd_A, cmd_B, A, B;
  logic [3:0]    cmd_Sel, ALU_Sel, res_Sel;
  logic [15:0]   ALU_Out, res_Data;
  logic          CarryOut, res_Carry, res_Zero, res_DivErr;
  logic [CW-1:0] count;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  logic rnd_on = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_Sel(cmd_Sel),
    .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_Data(res_Data), .res_Sel(res_Sel),
    .res_Carry(res_Carry), .res_Zero(res_Zero), .res_DivErr(res_DivErr),
    .count(count)
  );

  // Behavioural ALU; carry is the raw A+B bit 8 regardless of opcode.
  function automatic logic [16:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [8:0]  sum;
    logic [15:0] o;
    sum = {1'b0, a} + {1'b0, b};
    case (s)
      4'b0000: o = {7'b0, sum};
      4'b0001: o = {8'h00, 8'(a - b)};
      4'b0010: o = {8'h00, a} * {8'h00, b};
      4'b0011: o = (b == 8'd0) ? 16'h0000 : {8'h00, 8'(a / b)};
      4'b0100: o = {8'h00, a[6:0], 1'b0};
      4'b0101: o = {8'h00, 1'b0, a[7:1]};
      4'b0110: o = {8'h00, a[6:0], a[7]};
      4'b0111: o = {8'h00, a[0], a[7:1]};
      4'b1000: o = {8'h00, a & b};
      4'b1001: o = {8'h00, a | b};
      4'b1010: o = {8'h00, a ^ b};
      4'b1011: o = {8'h00, ~(a | b)};
      4'b1100: o = {8'h00, ~(a & b)};
      4'b1101: o = {8'h00, ~(a ^ b)};
      4'b1110: o = {15'b0, (a > b)};
      default: o = {15'b0, (a == b)};
    endcase
    return {sum[8], o};
  endfunction

  always_comb {CarryOut, ALU_Out} = alu_ref(A, B, ALU_Sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input vec_t v);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_A     = v.a;
    cmd_B     = v.b;
    cmd_Sel   = v.sel;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end else begin
      @(posedge clk);
      exp_q.push_back(v);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    checks++;
    if (exp_q.size() != 0 || res_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, expected 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake; also checks outputs hold still while stalled.
  initial begin : monitor
    vec_t        v;
    logic        held;
    logic [22:0] hv;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && res_valid)
          chk("stall_stable", {res_Data, res_Sel, res_Carry, res_Zero, res_DivErr}, hv);
        if (res_valid && res_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data 0x%0h, expected no result", res_Data);
          end else begin
            v = exp_q.pop_front();
            chk("res_Data",   res_Data,   v.data);
            chk("res_Sel",    res_Sel,    v.sel);
            chk("res_Carry",  res_Carry,  v.carry);
            chk("res_Zero",   res_Zero,   v.zero);
            chk("res_DivErr", res_DivErr, v.diverr);
          end
        end else if (res_valid) begin
          held = 1'b1;
          hv   = {res_Data, res_Sel, res_Carry, res_Zero, res_DivErr};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t full5 [5] = '{
    '{8'h01, 8'h02, 4'b0000, 16'h0003, 1'b0, 1'b0, 1'b0},
    '{8'h09, 8'h04, 4'b0001, 16'h0005, 1'b0, 1'b0, 1'b0},
    '{8'h06, 8'h07, 4'b0010, 16'h002A, 1'b0, 1'b0, 1'b0},
    '{8'h80, 8'h80, 4'b0000, 16'h0100, 1'b1, 1'b0, 1'b0},
    '{8'h33, 8'h0F, 4'b1000, 16'h0003, 1'b0, 1'b0, 1'b0}
  };

  vec_t stream [16] = '{
    '{8'h03, 8'h04, 4'b0000, 16'h0007, 1'b0, 1'b0, 1'b0},
    '{8'h10, 8'h05, 4'b0001, 16'h000B, 1'b0, 1'b0, 1'b0},
    '{8'h0C, 8'h0B, 4'b0010, 16'h0084, 1'b0, 1'b0, 1'b0},
    '{8'h64, 8'h07, 4'b0011, 16'h000E, 1'b0, 1'b0, 1'b0},
    '{8'h81, 8'h00, 4'b0100, 16'h0002, 1'b0, 1'b0, 1'b0},
    '{8'h81, 8'h00, 4'b0101, 16'h0040, 1'b0, 1'b0, 1'b0},
    '{8'h81, 8'h00, 4'b0110, 16'h0003, 1'b0, 1'b0, 1'b0},
    '{8'h81, 8'h00, 4'b0111, 16'h00C0, 1'b0, 1'b0, 1'b0},
    '{8'hF0, 8'h3C, 4'b1000, 16'h0030, 1'b0, 1'b0, 1'b0},
    '{8'hF0, 8'h0F, 4'b1001, 16'h00FF, 1'b0, 1'b0, 1'b0},
    '{8'hFF, 8'hFF, 4'b0000, 16'h01FE, 1'b1, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 4'b0001, 16'h00FE, 1'b0, 1'b0, 1'b0},
    '{8'h0F, 8'hF0, 4'b1011, 16'h0000, 1'b0, 1'b1, 1'b0},
    '{8'h00, 8'h00, 4'b0011, 16'hFFFF, 1'b0, 1'b0, 1'b1},
    '{8'h05, 8'h03, 4'b1110, 16'h0001, 1'b0, 1'b0, 1'b0},
    '{8'h07, 8'h07, 4'b1111, 16'h0001, 1'b0, 1'b0, 1'b0}
  };

  initial begin : stim
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_A     = '0;
    cmd_B     = '0;
    cmd_Sel   = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count",     count,     0);
    chk("rst_alu_in",    {A, B, ALU_Sel}, 0);
    chk("rst_res",       {res_Data, res_Sel, res_Carry, res_Zero, res_DivErr}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First command and its two-edge latency
    res_ready = 1'b1;
    push('{8'hF0, 8'h20, 4'b0000, 16'h0110, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("lat_edge1_valid", res_valid, 0);
    chk("lat_edge1_count", count, 1);
    @(negedge clk);
    chk("lat_edge2_valid", res_valid, 1);
    drain("add");

    push('{8'd10, 8'd0, 4'b0011, 16'hFFFF, 1'b0, 1'b0, 1'b1});
    push('{8'd10, 8'd3, 4'b0011, 16'h0003, 1'b0, 1'b0, 1'b0});
    push('{8'h55, 8'h55, 4'b1010, 16'h0000, 1'b0, 1'b1, 1'b0});
    drain("div_xor");

    // Output stalled: one command parks in the result register, four fill the FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(full5[i]);
    @(negedge clk);
    chk("full_count",     count,     DEPTH);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_res_valid", res_valid, 1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    drain("full");

    // Reset mid-stream discards everything
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(stream[i]);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_count",     count,     0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_res_Data",  res_Data,  0);
    res_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst_still_empty", {res_valid, count}, 0);
    @(posedge clk);
    #1;

    // Stream with random consumer stalls; pointers wrap several times
    rnd_on = 1'b1;
    for (int i = 0; i < 16; i++) push(stream[i]);
    rnd_on = 1'b0;
    res_ready = 1'b1;
    drain("stream");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
